serial_word_receiver: RTL and testbench
=======================================

Name: serial_word_receiver

Overview:
- UART receive stage upstream of the CPU. Drives the CPU's SerialRead/SerialValid inputs.
- Samples the asynchronous RxD pin and deframes 8N1 bytes.
- Assembles byte pairs, low byte first, into 16-bit words.
- Holds each word for the controller until it is acknowledged.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200). Legal range 4..65535.
- SYNC_STAGES, 2, RxD synchronizer depth. Legal range 2..3.

Ports:
- Clock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- RxD  in  1  serial line, idle high; asynchronous to Clock.
- SerialAck  in  1  one-cycle pulse from the controller when it consumes SerialRead.
- SerialRead  out  16  last assembled word, {second byte, first byte}.
- SerialValid  out  1  high while SerialRead holds an unconsumed word.
- FrameError  out  1  one-cycle pulse when a stop bit samples low.
- Overrun  out  1  sticky; a completed word was dropped because SerialValid was still high.

Behaviour:
- Reset values while Reset=0:
  - SerialRead=0x0000, SerialValid=0, FrameError=0, Overrun=0.
  - Synchronizer flops=1, bit counter=0, state=IDLE, byte pointer=LOW.
- Reset applied mid-frame aborts the frame; the partial byte and the stored low byte are discarded.
- RxD passes through SYNC_STAGES flops before any use.
- State machine states: IDLE, START, DATA, STOP. PARITY is added only under the optional feature.
- IDLE:
  - A synchronized RxD of 0 loads the baud counter with CLKS_PER_BIT/2 (integer division) and moves to START.
- START:
  - When the counter expires, resample RxD.
  - RxD=0: load CLKS_PER_BIT, clear the bit index, go to DATA.
  - RxD=1: treat as a glitch and return to IDLE. No flags change.
- DATA:
  - Sample once per CLKS_PER_BIT, near mid-bit, LSB first, into a shift register.
  - After 8 samples, go to STOP.
- STOP, on sample:
  - RxD=1: accept the byte and return to IDLE.
  - RxD=0: pulse FrameError for one cycle, discard the byte, reset the byte pointer to LOW, and go to IDLE.
  - The line must return high before the next start bit is detected: IDLE detects a level, so a held-low line retriggers START.
- Word assembly:
  - Accepted byte with pointer=LOW: latch it as the low half and set pointer=HIGH.
  - Accepted byte with pointer=HIGH: the word completes; set pointer=LOW.
- Word completion handshake:
  - SerialValid=0: SerialRead <= {byte, low}, and SerialValid=1 on the next edge.
  - SerialValid=1 with SerialAck=1 in the same cycle: load the new word; SerialValid stays 1.
  - SerialValid=1 with SerialAck=0: discard the new word, keep the old one, set Overrun=1.
- SerialAck with no completion that cycle clears SerialValid on the next edge. SerialRead is left unchanged.
- SerialAck also clears Overrun. If an overrun occurs in the same cycle as the ack, the overrun wins.
- SerialAck while SerialValid=0 is ignored.
- Latency: SerialValid rises exactly 1 cycle after the stop-bit sample edge of the second byte.
- Counter width is 16 bits. The counter reloads on expiry and never wraps through 0.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state between DATA and STOP samples the 9th bit.
  - If the XOR of the 8 data bits and the parity bit is 1, pulse FrameError, discard the byte, reset the pointer to LOW, and go to IDLE without sampling the stop bit.
- Undefined: the PARITY state and its logic are absent; the frame is 8N1.

Decomposition:
- Shared package serial_pkg holds:
  - the state encoding typedef (IDLE, START, DATA, PARITY, STOP);
  - the constants BYTE_BITS=8 and WORD_BITS=16.
- One sub-module, serial_byte_rx, contains:
  - the synchronizer, baud counter and framing FSM;
  - outputs byte_data[7:0], byte_strobe and frame_err.
- The top level contains the byte pointer, the word latch, the Valid/Ack handshake and Overrun.

Test Plan (bench uses CLKS_PER_BIT=16):
- Reset: hold Reset low, then release. Required: SerialRead=0x0000, SerialValid=0, Overrun=0; RxD idle causes no activity.
- Single word: send 0x34 then 0x12, then hold SerialAck low. Required: SerialRead=0x1234 and SerialValid=1, asserted 1 cycle after the second stop-bit sample and held.
- Glitch and frame error:
  - Pulse RxD low for 4 cycles. Required: no state change.
  - Send 0x55 with the stop bit low. Required: FrameError pulses 1 cycle.
  - Then send 0xCD, 0xAB. Required: word 0xABCD, showing the pointer was reset.
- Overrun: with SerialValid=1 (0x1234), send 0x78, 0x56 with no ack. Required: Overrun=1 and SerialRead stays 0x1234. SerialAck then clears Overrun and SerialValid.
- Ack collision: pulse SerialAck in the same cycle the word 0x9ABC completes. Required: SerialRead=0x9ABC, SerialValid remains 1, Overrun=0.
- Reset mid-frame: assert Reset during DATA of the second byte. Required: all outputs return to reset values, and the next pair 0x01, 0x00 yields 0x0001.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial word receiver: framing FSM state
// encoding, byte pointer encoding and bus widths.
// Latency: n/a.  Backpressure: n/a.
package serial_pkg;

  localparam int unsigned BYTE_BITS = 8;
  localparam int unsigned WORD_BITS = 16;

  // PARITY is only reachable when SERIAL_RX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  typedef enum logic {
    PTR_LOW  = 1'b0,
    PTR_HIGH = 1'b1
  } byte_ptr_e;

endpackage

// File: rtl/serial_byte_rx.sv
// Purpose: synchronize RxD, time bits with a 16-bit baud counter and deframe
//   8N1 bytes (8E1 when SERIAL_RX_PARITY_EN is defined).
// Latency: byte_strobe/frame_err are registered, high the cycle after the
//   stop-bit (or parity-bit) sample edge.  Backpressure: none, strobes are
//   single-cycle pulses the consumer must take.
// Ports: Clock, Reset (async active-low), RxD (async serial line) in;
//   byte_data[7:0] (last shifted byte), byte_strobe, frame_err out.
module serial_byte_rx
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 RxD,
  output logic [BYTE_BITS-1:0] byte_data,
  output logic                 byte_strobe,
  output logic                 frame_err
);

  localparam int unsigned IDX_W    = $clog2(BYTE_BITS);
  localparam logic [15:0] FULL_BIT = 16'(CLKS_PER_BIT);
  localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  rx_state_e              state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [BYTE_BITS-1:0]   shift_q, shift_d;
  logic                   strobe_q, strobe_d;
  logic                   ferr_q, ferr_d;
  logic                   tick;

  assign rx_s = sync_q[SYNC_STAGES-1];
  // Counter counts down to 1 and reloads there, so a load of N expires
  // exactly N cycles later and the counter never passes through zero.
  assign tick = (cnt_q == 16'd1);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync_q    <= '1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      strobe_q  <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], RxD};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      strobe_q  <= strobe_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q > 16'd1) ? cnt_q - 16'd1 : FULL_BIT;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    strobe_d  = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // Level detect: a line still low after a bad stop bit retriggers.
        if (!rx_s) begin
          cnt_d   = HALF_BIT;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s) begin
            bit_idx_d = '0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d   = {rx_s, shift_q[BYTE_BITS-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == IDX_W'(BYTE_BITS - 1)) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        // Even parity: data bits plus parity bit must XOR to zero.
        if (tick) begin
          if (^{shift_q, rx_s}) begin
            ferr_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = STOP;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (rx_s) strobe_d = 1'b1;
          else      ferr_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_data   = shift_q;
  assign byte_strobe = strobe_q;
  assign frame_err   = ferr_q;

endmodule

// File: rtl/serial_word_receiver.sv
// Purpose: UART receive stage feeding the CPU; pairs deframed bytes (low
//   first) into 16-bit words and holds each until SerialAck.
// Latency: SerialValid rises 1 cycle after the second byte's stop sample.
// Backpressure: none upstream; a word completing while SerialValid is still
//   high without an ack is dropped and flagged on sticky Overrun.
// Ports: Clock, Reset (async active-low), RxD, SerialAck in;
//   SerialRead[15:0], SerialValid, FrameError (pulse), Overrun (sticky) out.
// Optional: define SERIAL_RX_PARITY_EN for 8E1 framing with parity check.
module serial_word_receiver
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 RxD,
  input  logic                 SerialAck,
  output logic [WORD_BITS-1:0] SerialRead,
  output logic                 SerialValid,
  output logic                 FrameError,
  output logic                 Overrun
);

  logic [BYTE_BITS-1:0] rx_byte;
  logic                 rx_strobe;
  logic                 rx_ferr;

  byte_ptr_e            ptr_q, ptr_d;
  logic [BYTE_BITS-1:0] low_q, low_d;
  logic [WORD_BITS-1:0] read_q, read_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;
  logic                 word_done;

  serial_byte_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_byte_rx (
    .Clock       (Clock),
    .Reset       (Reset),
    .RxD         (RxD),
    .byte_data   (rx_byte),
    .byte_strobe (rx_strobe),
    .frame_err   (rx_ferr)
  );

  assign word_done = rx_strobe && (ptr_q == PTR_HIGH);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ptr_q   <= PTR_LOW;
      low_q   <= '0;
      read_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      low_q   <= low_d;
      read_q  <= read_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    low_d   = low_q;
    read_d  = read_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    // A framing error realigns pairing so the next good byte is a low byte.
    if (rx_ferr) begin
      ptr_d = PTR_LOW;
    end else if (rx_strobe) begin
      if (ptr_q == PTR_LOW) begin
        low_d = rx_byte;
        ptr_d = PTR_HIGH;
      end else begin
        ptr_d = PTR_LOW;
      end
    end

    if (SerialAck && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    // Evaluated after the ack so a same-cycle overrun takes precedence.
    if (word_done) begin
      if (!valid_q || SerialAck) begin
        read_d  = {rx_byte, low_q};
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign SerialRead  = read_q;
  assign SerialValid = valid_q;
  assign FrameError  = rx_ferr;
  assign Overrun     = ovr_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
module tb_serial_word_receiver;

  localparam int CLKS = 16;
  localparam int SYNC = 2;
  // Fall of start bit -> SerialValid visible: synchronizer, idle detect,
  // half bit to mid-start, 9 full bits to mid-stop, one cycle to register.
  localparam int LAT  = SYNC + 1 + CLKS / 2 + 9 * CLKS + 1;

  logic        Clock;
  logic        Reset;
  logic        RxD;
  logic        SerialAck;
  logic [15:0] SerialRead;
  logic        SerialValid;
  logic        FrameError;
  logic        Overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int rise_cyc = -1;
  logic prev_valid = 1'b0;

  serial_word_receiver #(
    .CLKS_PER_BIT (CLKS),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .RxD         (RxD),
    .SerialAck   (SerialAck),
    .SerialRead  (SerialRead),
    .SerialValid (SerialValid),
    .FrameError  (FrameError),
    .Overrun     (Overrun)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) cyc++;

  always @(negedge Clock) begin
    if (FrameError) fe_cnt++;
    if (SerialValid && !prev_valid) rise_cyc = cyc;
    prev_valid = SerialValid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One UART frame, LSB first, each bit CLKS cycles, then idle-high cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int idle, output int c0);
    @(negedge Clock);
    RxD = 1'b0;
    c0  = cyc;
    repeat (CLKS) @(negedge Clock);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (CLKS) @(negedge Clock);
    end
    RxD = stop_bit;
    repeat (CLKS) @(negedge Clock);
    RxD = 1'b1;
    repeat (idle) @(negedge Clock);
  endtask

  task automatic pulse_ack();
    @(negedge Clock);
    SerialAck = 1'b1;
    @(negedge Clock);
    SerialAck = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0; RxD = 1'b1; SerialAck = 1'b0;
    repeat (5) @(negedge Clock);
    checks++; if (SerialRead !== 16'h0000) begin errors++; $display("FAIL reset_read got %h exp 0000", SerialRead); end
    checks++; if (SerialValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", SerialValid); end
    checks++; if (Overrun !== 1'b0 || FrameError !== 1'b0) begin errors++; $display("FAIL reset_flags got ovr=%b fe=%b exp 0 0", Overrun, FrameError); end
    Reset = 1'b1;
    repeat (40) @(negedge Clock);
    checks++; if (SerialValid !== 1'b0 || SerialRead !== 16'h0000 || Overrun !== 1'b0 || fe_cnt !== 0) begin
      errors++; $display("FAIL idle_quiet got v=%b r=%h o=%b fe=%0d exp 0 0000 0 0", SerialValid, SerialRead, Overrun, fe_cnt);
    end
  endtask

  task automatic test_single_word();
    int c0a, c0b;
    rise_cyc = -1;
    send_frame(8'h34, 1'b1, 0, c0a);
    send_frame(8'h12, 1'b1, 20, c0b);
    checks++; if (SerialRead !== 16'h1234) begin errors++; $display("FAIL single_read got %h exp 1234", SerialRead); end
    checks++; if (SerialValid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", SerialValid); end
    checks++; if (rise_cyc !== c0b + LAT) begin errors++; $display("FAIL single_latency got %0d exp %0d", rise_cyc - c0b, LAT); end
    checks++; if (Overrun !== 1'b0) begin errors++; $display("FAIL single_ovr got %b exp 0", Overrun); end
  endtask

  task automatic test_overrun();
    int c0;
    send_frame(8'h78, 1'b1, 0, c0);
    send_frame(8'h56, 1'b1, 10, c0);
    checks++; if (Overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", Overrun); end
    checks++; if (SerialRead !== 16'h1234 || SerialValid !== 1'b1) begin errors++; $display("FAIL ovr_hold got r=%h v=%b exp 1234 1", SerialRead, SerialValid); end
    pulse_ack();
    checks++; if (Overrun !== 1'b0 || SerialValid !== 1'b0) begin errors++; $display("FAIL ovr_ack got o=%b v=%b exp 0 0", Overrun, SerialValid); end
    checks++; if (SerialRead !== 16'h1234) begin errors++; $display("FAIL ack_keeps_read got %h exp 1234", SerialRead); end
  endtask

  task automatic test_glitch_frame_error();
    int c0, fe0;
    fe0 = fe_cnt;
    @(negedge Clock); RxD = 1'b0;
    repeat (4) @(negedge Clock); RxD = 1'b1;
    repeat (3 * CLKS) @(negedge Clock);
    checks++; if (fe_cnt !== fe0 || SerialValid !== 1'b0 || Overrun !== 1'b0 || SerialRead !== 16'h1234) begin
      errors++; $display("FAIL glitch got fe=%0d v=%b o=%b r=%h exp %0d 0 0 1234", fe_cnt, SerialValid, Overrun, SerialRead, fe0);
    end
    send_frame(8'h34, 1'b1, 0, c0);
    send_frame(8'h55, 1'b0, 40, c0);
    checks++; if (fe_cnt !== fe0 + 1) begin errors++; $display("FAIL fe_pulse got %0d cycles exp 1", fe_cnt - fe0); end
    send_frame(8'hCD, 1'b1, 0, c0);
    send_frame(8'hAB, 1'b1, 10, c0);
    checks++; if (SerialRead !== 16'hABCD || SerialValid !== 1'b1) begin errors++; $display("FAIL fe_realign got r=%h v=%b exp abcd 1", SerialRead, SerialValid); end
  endtask

  task automatic test_ack_collision();
    int c0;
    send_frame(8'hBC, 1'b1, 0, c0);
    fork
      send_frame(8'h9A, 1'b1, 10, c0);
      begin
        @(negedge Clock);
        repeat (LAT - 1) @(negedge Clock);
        SerialAck = 1'b1;
        @(negedge Clock);
        SerialAck = 1'b0;
      end
    join
    checks++; if (SerialRead !== 16'h9ABC) begin errors++; $display("FAIL coll_read got %h exp 9abc", SerialRead); end
    checks++; if (SerialValid !== 1'b1 || Overrun !== 1'b0) begin errors++; $display("FAIL coll_flags got v=%b o=%b exp 1 0", SerialValid, Overrun); end
  endtask

  task automatic test_reset_mid_frame();
    int c0;
    send_frame(8'h11, 1'b1, 0, c0);
    @(negedge Clock); RxD = 1'b0;
    repeat (CLKS) @(negedge Clock);
    for (int i = 0; i < 3; i++) begin
      RxD = i[0];
      repeat (CLKS) @(negedge Clock);
    end
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    checks++; if (SerialRead !== 16'h0000 || SerialValid !== 1'b0 || Overrun !== 1'b0 || FrameError !== 1'b0) begin
      errors++; $display("FAIL midreset got r=%h v=%b o=%b fe=%b exp 0000 0 0 0", SerialRead, SerialValid, Overrun, FrameError);
    end
    RxD = 1'b1;
    @(negedge Clock);
    Reset = 1'b1;
    repeat (40) @(negedge Clock);
    send_frame(8'h01, 1'b1, 0, c0);
    send_frame(8'h00, 1'b1, 10, c0);
    checks++; if (SerialRead !== 16'h0001 || SerialValid !== 1'b1) begin errors++; $display("FAIL midreset_word got r=%h v=%b exp 0001 1", SerialRead, SerialValid); end
  endtask

  // Reference: bytes pair low-first; a bad stop restarts pairing; a word is
  // captured only when nothing is pending, otherwise it raises Overrun.
  task automatic test_random();
    logic [15:0] exp_read;
    logic        exp_valid, exp_ovr, have_low;
    logic [7:0]  low, b;
    int          c0, fe0, exp_fe;
    exp_read = 16'h0001; exp_valid = 1'b1; exp_ovr = 1'b0; have_low = 1'b0; low = 8'h00;
    fe0 = fe_cnt; exp_fe = 0;
    for (int n = 0; n < 20; n++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 9) < 2) begin
        send_frame(b, 1'b0, 40, c0);
        have_low = 1'b0;
        exp_fe++;
      end else begin
        send_frame(b, 1'b1, $urandom_range(0, 3), c0);
        if (!have_low) begin
          low = b; have_low = 1'b1;
        end else begin
          have_low = 1'b0;
          if (!exp_valid) begin exp_read = {b, low}; exp_valid = 1'b1; end
          else exp_ovr = 1'b1;
        end
      end
      repeat (CLKS) @(negedge Clock);
      checks++; if (SerialRead !== exp_read || SerialValid !== exp_valid || Overrun !== exp_ovr || fe_cnt - fe0 !== exp_fe) begin
        errors++; $display("FAIL rand_%0d got r=%h v=%b o=%b fe=%0d exp %h %b %b %0d", n, SerialRead, SerialValid, Overrun, fe_cnt - fe0, exp_read, exp_valid, exp_ovr, exp_fe);
      end
      if ($urandom_range(0, 9) < 4) begin
        pulse_ack();
        if (exp_valid) begin exp_valid = 1'b0; exp_ovr = 1'b0; end
        checks++; if (SerialValid !== exp_valid || Overrun !== exp_ovr || SerialRead !== exp_read) begin
          errors++; $display("FAIL rand_ack_%0d got v=%b o=%b r=%h exp %b %b %h", n, SerialValid, Overrun, SerialRead, exp_valid, exp_ovr, exp_read);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_overrun();
    test_glitch_frame_error();
    test_ack_collision();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
